// File: rtl/pll_reset_ctrl_if.sv
// Status/control bundle between the PLL reset controller and the PLL plus core logic.
// master = controller (drives PLL reset and status); slave = PLL/core side (drives lock).
interface pll_reset_ctrl_if;
  localparam int unsigned RETRY_W = 2;
  localparam int unsigned LOSS_W  = 8;

  logic               pll_locked;
  logic               pll_rst;
  logic               core_reset;
  logic               ready;
  logic               fail;
  logic [RETRY_W-1:0] retry_cnt;
  logic [LOSS_W-1:0]  lock_losses;

  modport master (
    input  pll_locked,
    output pll_rst, core_reset, ready, fail, retry_cnt, lock_losses
  );

  modport slave (
    output pll_locked,
    input  pll_rst, core_reset, ready, fail, retry_cnt, lock_losses
  );
endinterface

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable synchronised lock, then releases the core.
// Optional macro PLL_RST_AUTORETRY_EN: lock loss in RUN triggers a full PLL re-reset instead of a re-wait.
module pll_reset_ctrl #(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 65536,
  parameter int unsigned MAX_RETRIES      = 3
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  pll_reset_ctrl_if.master   ctrl
);

  localparam int unsigned MAX_AB  = (RST_PULSE_CYC > LOCK_STABLE_CYC) ? RST_PULSE_CYC : LOCK_STABLE_CYC;
  localparam int unsigned CNT_MAX = (MAX_AB > LOCK_TIMEOUT_CYC) ? MAX_AB : LOCK_TIMEOUT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sync1_q;
  logic             sync2_q;
  logic             pll_rst_q;
  logic             core_reset_q;
  logic             ready_q;
  logic             fail_q;
  logic [1:0]       retry_q;
  logic [7:0]       losses_q;

  assign ctrl.pll_rst     = pll_rst_q;
  assign ctrl.core_reset  = core_reset_q;
  assign ctrl.ready       = ready_q;
  assign ctrl.fail        = fail_q;
  assign ctrl.retry_cnt   = retry_q;
  assign ctrl.lock_losses = losses_q;

  // sync2_q is locked_s; the FSM always acts on its registered value
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q      <= S_PLL_RST;
      cnt_q        <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      pll_rst_q    <= 1'b1;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
      retry_q      <= '0;
      losses_q     <= '0;
    end else begin
      sync1_q <= ctrl.pll_locked;
      sync2_q <= sync1_q;

      case (state_q)
        S_PLL_RST: begin
          if (cnt_q == CNT_W'(RST_PULSE_CYC - 1)) begin
            state_q   <= S_WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        // lock seen on the timeout cycle takes priority over the retry
        S_WAIT_LOCK: begin
          if (sync2_q) begin
            state_q <= S_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
            cnt_q <= '0;
            if (32'(retry_q) < MAX_RETRIES) begin
              state_q   <= S_PLL_RST;
              pll_rst_q <= 1'b1;
              if (retry_q != 2'd3) retry_q <= retry_q + 2'd1;
            end else begin
              state_q <= S_FAIL;
              fail_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_STABLE: begin
          if (!sync2_q) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(LOCK_STABLE_CYC - 1)) begin
            state_q      <= S_RUN;
            cnt_q        <= '0;
            core_reset_q <= 1'b0;
            ready_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_RUN: begin
          if (!sync2_q) begin
            cnt_q        <= '0;
            core_reset_q <= 1'b1;
            ready_q      <= 1'b0;
            if (losses_q != 8'hFF) losses_q <= losses_q + 8'd1;
`ifdef PLL_RST_AUTORETRY_EN
            state_q   <= S_PLL_RST;
            pll_rst_q <= 1'b1;
            retry_q   <= '0;
`else
            state_q   <= S_WAIT_LOCK;
`endif
          end
        end

        S_FAIL: begin
          pll_rst_q    <= 1'b0;
          core_reset_q <= 1'b1;
          ready_q      <= 1'b0;
          fail_q       <= 1'b1;
        end

        default: begin
          state_q      <= S_PLL_RST;
          cnt_q        <= '0;
          pll_rst_q    <= 1'b1;
          core_reset_q <= 1'b1;
          ready_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
